// File: rtl/button_conditioner.sv
// Per-button two-flop synchroniser plus debounce FSM producing clean level/press/release signals.
// Optional auto-repeat of btn_press while held is enabled by defining BUTTON_AUTOREPEAT_EN.
module button_conditioner #(
  parameter int unsigned N_BTN           = 3,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned REPEAT_DELAY    = 50000000,
  parameter int unsigned REPEAT_PERIOD   = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release
);

  localparam logic [1:0] S_LOW  = 2'd0;
  localparam logic [1:0] S_RISE = 2'd1;
  localparam logic [1:0] S_HIGH = 2'd2;
  localparam logic [1:0] S_FALL = 2'd3;

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  // Transition fires on the edge where the counter would step to DEBOUNCE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

`ifdef BUTTON_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    logic             s1_q, s2_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             rep_pulse;

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q      <= 1'b0;
        s2_q      <= 1'b0;
        state_q   <= S_LOW;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        s1_q      <= btn_in[i];
        s2_q      <= s1_q;
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      unique case (state_q)
        S_LOW: begin
          if (s2_q) begin
            state_d = S_RISE;
            cnt_d   = '0;
          end
        end
        S_RISE: begin
          if (!s2_q) begin
            state_d = S_LOW;
          end else if (cnt_q == CNT_PRE_LAST) begin
            state_d = S_HIGH;
            cnt_d   = cnt_q + 1'b1;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_HIGH: begin
          if (!s2_q) begin
            state_d = S_FALL;
            cnt_d   = '0;
          end
        end
        S_FALL: begin
          if (s2_q) begin
            state_d = S_HIGH;
          end else if (cnt_q == CNT_PRE_LAST) begin
            state_d   = S_LOW;
            cnt_d     = cnt_q + 1'b1;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_LOW;
      endcase
      if (rep_pulse) begin
        press_d = 1'b1;
      end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_first_q, rep_first_d;

    always_ff @(posedge clk) begin
      if (rst) begin
        rep_cnt_q   <= '0;
        rep_first_q <= 1'b1;
      end else begin
        rep_cnt_q   <= rep_cnt_d;
        rep_first_q <= rep_first_d;
      end
    end

    // Counts only while staying in S_HIGH; S_FALL holds the count so a bounce resumes it.
    always_comb begin
      rep_cnt_d   = rep_cnt_q;
      rep_first_d = rep_first_q;
      rep_pulse   = 1'b0;
      if (state_q == S_HIGH && s2_q) begin
        if (rep_first_q ? (rep_cnt_q == REP_DELAY_LAST) : (rep_cnt_q == REP_PERIOD_LAST)) begin
          rep_pulse   = 1'b1;
          rep_cnt_d   = '0;
          rep_first_d = 1'b0;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end else if (state_q == S_LOW || state_q == S_RISE) begin
        rep_cnt_d   = '0;
        rep_first_d = 1'b1;
      end
    end
`else
    assign rep_pulse = 1'b0;
`endif

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = release_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios plus randomized stimulus
// against a run-length reference model of the debounce rules.
`timescale 1ns/1ps
module tb_button_conditioner;
  localparam int unsigned N  = 3;
  localparam int unsigned D  = 4;
  localparam int unsigned RD = 20;
  localparam int unsigned RP = 8;
`ifdef BUTTON_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_in = '0;
  logic [N-1:0] btn_level, btn_press, btn_release;

  int n_checks = 0;
  int n_fail   = 0;

  button_conditioner #(
    .N_BTN          (N),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_in     (btn_in),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  // Reference model: the FSM sees the pin two edges late; the level flips once D consecutive
  // observations disagree with it. held counts edges spent holding an accepted press.
  logic [N-1:0] m_p1 = '0, m_p2 = '0;
  logic [N-1:0] m_level = '0, m_press = '0, m_release = '0;
  int           m_run  [N];
  int           m_held [N];

  function automatic bit repeat_due(input int held);
    return (held == RD) || (held > RD && ((held - RD) % RP) == 0);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      automatic int run  = m_run[i];
      automatic int held = m_held[i];
      automatic bit lvl  = m_level[i];
      automatic bit prs  = 1'b0;
      automatic bit rel  = 1'b0;
      if (rst) begin
        run  = 0;
        held = 0;
        lvl  = 1'b0;
      end else if (m_p2[i] == lvl) begin
        if (lvl && run == 0) begin
          held = held + 1;
          prs  = AUTOREPEAT && repeat_due(held);
        end
        run = 0;
      end else begin
        run = run + 1;
        if (run == D) begin
          lvl  = !lvl;
          run  = 0;
          held = 0;
          prs  = lvl;
          rel  = !lvl;
        end
      end
      m_run[i]     <= run;
      m_held[i]    <= held;
      m_level[i]   <= lvl;
      m_press[i]   <= prs;
      m_release[i] <= rel;
      m_p2[i]      <= rst ? 1'b0 : m_p1[i];
      m_p1[i]      <= rst ? 1'b0 : btn_in[i];
    end
  end

  task automatic test_reset();
    logic [N-1:0] exp_l, exp_p;
    rst    = 1'b1;
    btn_in = '1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d: level/press/release=%b/%b/%b, expected all zero",
                 k, btn_level, btn_press, btn_release);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp_l = (k >= 5) ? 3'b111 : 3'b000;
      exp_p = (k == 5) ? 3'b111 : 3'b000;
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== {exp_l, exp_p, 3'b000}) begin
        n_fail++;
        $display("FAIL reset_held_press k=%0d: level/press/release=%b/%b/%b, expected %b/%b/000",
                 k, btn_level, btn_press, btn_release, exp_l, exp_p);
      end
    end
  endtask

  task automatic test_release();
    logic [N-1:0] exp_l, exp_r;
    btn_in = 3'b000;
    @(negedge clk);
    btn_in = 3'b111;
    @(negedge clk);
    btn_in = 3'b000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp_l = (k >= 5) ? 3'b000 : 3'b111;
      exp_r = (k == 5) ? 3'b111 : 3'b000;
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== {exp_l, 3'b000, exp_r}) begin
        n_fail++;
        $display("FAIL release_bounce k=%0d: level/press/release=%b/%b/%b, expected %b/000/%b",
                 k, btn_level, btn_press, btn_release, exp_l, exp_r);
      end
    end
  endtask

  task automatic test_clean_press();
    logic [N-1:0] exp_l, exp_p;
    btn_in = 3'b010;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp_l = (k >= 5) ? 3'b010 : 3'b000;
      exp_p = (k == 5) ? 3'b010 : 3'b000;
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== {exp_l, exp_p, 3'b000}) begin
        n_fail++;
        $display("FAIL clean_press k=%0d: level/press/release=%b/%b/%b, expected %b/%b/000",
                 k, btn_level, btn_press, btn_release, exp_l, exp_p);
      end
    end
  endtask

  task automatic test_bounce();
    // LSB first: 2-cycle toggles, quiet, 3-cycle pulse, quiet
    logic [24:0]  pat = 25'b0000_0000_1110_0000_0000_1100_11;
    logic [N-1:0] exp_l, exp_p;
    for (int j = 0; j < 25; j++) begin
      btn_in = {2'b01, pat[j]};
      @(negedge clk);
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== {3'b010, 3'b000, 3'b000}) begin
        n_fail++;
        $display("FAIL bounce_reject j=%0d: level/press/release=%b/%b/%b, expected 010/000/000",
                 j, btn_level, btn_press, btn_release);
      end
    end
    btn_in = 3'b011;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp_l = (k >= 5) ? 3'b011 : 3'b010;
      exp_p = (k == 5) ? 3'b001 : 3'b000;
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== {exp_l, exp_p, 3'b000}) begin
        n_fail++;
        $display("FAIL bounce_then_hold k=%0d: level/press/release=%b/%b/%b, expected %b/%b/000",
                 k, btn_level, btn_press, btn_release, exp_l, exp_p);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] exp_l, exp_p;
    btn_in = 3'b000;
    repeat (10) @(negedge clk);
    n_checks++;
    if (btn_level !== 3'b000) begin
      n_fail++;
      $display("FAIL simul_idle: level=%b, expected 000", btn_level);
    end
    btn_in = 3'b101;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp_l = (k >= 5) ? 3'b101 : 3'b000;
      exp_p = (k == 5) ? 3'b101 : 3'b000;
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== {exp_l, exp_p, 3'b000}) begin
        n_fail++;
        $display("FAIL simultaneous k=%0d: level/press/release=%b/%b/%b, expected %b/%b/000",
                 k, btn_level, btn_press, btn_release, exp_l, exp_p);
      end
    end
  endtask

  task automatic test_autorepeat();
    int           exp_ks[$];
    bit           hit;
    logic [N-1:0] exp_l, exp_p, exp_r;
    if (AUTOREPEAT) exp_ks = '{5, 25, 33, 41, 49, 57};
    else            exp_ks = '{5};
    btn_in = 3'b000;
    repeat (10) @(negedge clk);
    n_checks++;
    if (btn_level !== 3'b000) begin
      n_fail++;
      $display("FAIL repeat_idle: level=%b, expected 000", btn_level);
    end
    btn_in = 3'b100;
    for (int k = 0; k <= 80; k++) begin
      @(negedge clk);
      hit = 1'b0;
      foreach (exp_ks[j]) if (exp_ks[j] == k) hit = 1'b1;
      exp_l = (k >= 5 && k < 68) ? 3'b100 : 3'b000;
      exp_p = hit ? 3'b100 : 3'b000;
      exp_r = (k == 68) ? 3'b100 : 3'b000;
      n_checks++;
      if ({btn_level, btn_press, btn_release} !== {exp_l, exp_p, exp_r}) begin
        n_fail++;
        $display("FAIL autorepeat k=%0d: level/press/release=%b/%b/%b, expected %b/%b/%b",
                 k, btn_level, btn_press, btn_release, exp_l, exp_p, exp_r);
      end
      if (k == 62) btn_in = 3'b000;
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 300; s++) begin
      automatic int           len    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 40))
                                                                   : int'($urandom_range(1, 6));
      automatic logic [N-1:0] v      = N'($urandom);
      automatic bit           do_rst = ($urandom_range(0, 40) == 0);
      rst    = do_rst;
      btn_in = v;
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        n_checks++;
        if ({btn_level, btn_press, btn_release} !== {m_level, m_press, m_release}) begin
          n_fail++;
          $display("FAIL random s=%0d c=%0d: level/press/release=%b/%b/%b, expected %b/%b/%b",
                   s, c, btn_level, btn_press, btn_release, m_level, m_press, m_release);
        end
        n_checks++;
        if ((btn_press & btn_release) !== 3'b000) begin
          n_fail++;
          $display("FAIL press_release_overlap s=%0d: press=%b release=%b, expected disjoint",
                   s, btn_press, btn_release);
        end
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_autorepeat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
